// File: rtl/inverter_bist_ctrl_if.sv
// Signal bundle between the inverter BIST sequencer (slave) and its requester/cell wiring (master).
interface inverter_bist_ctrl_if #(
  parameter int NUM_VECTORS = 4
);
  localparam int FC_W = $clog2(NUM_VECTORS + 1);
  localparam int VI_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

  logic            start;
  logic            resp;
  logic            stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic            mismatch;
  logic [FC_W-1:0] fail_count;
  logic [VI_W-1:0] vec_idx;

  modport master (
    output start, resp,
    input  stim, busy, done, pass, mismatch, fail_count, vec_idx
  );

  modport slave (
    input  start, resp,
    output stim, busy, done, pass, mismatch, fail_count, vec_idx
  );
endinterface

// File: rtl/inverter_bist_ctrl.sv
// Clocked self-checking stimulus sequencer for one inverter cell (stim -> cell -> resp).
// Optional INV_BIST_ABORT_EN: end the run at the first mismatching vector.
module inverter_bist_ctrl #(
  parameter int                     NUM_VECTORS   = 4,
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0] PATTERN       = 4'b0101
) (
  input  logic                 clk,
  input  logic                 rst,
  inverter_bist_ctrl_if.slave  bist
);
  localparam int FC_W  = $clog2(NUM_VECTORS + 1);
  localparam int VI_W  = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [VI_W-1:0]  VEC_LAST = VI_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // IDLE: wait for start | SETTLE: hold stim | CHECK: compare resp | DONE: publish verdict
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VI_W-1:0]  vec_q, vec_d, vec_nxt;
  logic [FC_W-1:0]  fail_q, fail_d;
  logic             stim_q, stim_d;
  logic             pass_q, pass_d;
  logic             busy_c, done_c, mismatch_c;
  logic             resp_bad;

  // A healthy inverter returns the complement, so equality means a fault.
  assign resp_bad = (bist.resp == stim_q);
  assign vec_nxt  = vec_q + VI_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      fail_q  <= '0;
      stim_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      fail_q  <= fail_d;
      stim_q  <= stim_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    fail_d     = fail_q;
    stim_d     = stim_q;
    pass_d     = pass_q;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    mismatch_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bist.start) begin
          stim_d  = PATTERN[0];
          vec_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        busy_c = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CHECK: begin
        busy_c = 1'b1;
        if (resp_bad) begin
          mismatch_c = 1'b1;
          fail_d     = fail_q + FC_W'(1);
        end
`ifdef INV_BIST_ABORT_EN
        if (resp_bad || (vec_q == VEC_LAST)) begin
`else
        if (vec_q == VEC_LAST) begin
`endif
          state_d = DONE;
        end else begin
          vec_d   = vec_nxt;
          stim_d  = PATTERN[vec_nxt];
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end

      DONE: begin
        done_c  = 1'b1;
        pass_d  = (fail_q == '0);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bist.stim       = stim_q;
  assign bist.busy       = busy_c;
  assign bist.done       = done_c;
  assign bist.pass       = pass_q;
  assign bist.mismatch   = mismatch_c;
  assign bist.fail_count = fail_q;
  assign bist.vec_idx    = vec_q;
endmodule
